// File: rtl/memory_access_unit.sv
// memory_access_unit: sub-word load/store engine doing read-modify-write over a word-wide data memory
module memory_access_unit (
  input  logic        system_clock,
  input  logic        system_reset_n,
  input  logic        request_valid,
  output logic        request_ready,
  input  logic        request_write,
  input  logic [1:0]  request_size,
  input  logic        request_signed,
  input  logic [31:0] request_address,
  input  logic [31:0] request_write_data,
  output logic        response_valid,
  output logic [31:0] response_read_data,
  output logic        response_error,
  output logic        mem_write_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);
  typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;
  state_t state;
  logic [1:0] size_q, lane_q;
  logic signed_q;
  logic request_fault;
  logic [4:0] shift;
  logic [31:0] lane_data, lane_mask, load_data, merged_data;
  assign request_ready = state == IDLE;
  assign request_fault = request_size == 2'b11 || (request_size == 2'b01 && request_address[0]) ||
                         (request_size == 2'b10 && request_address[1:0] != 2'b00);
  assign shift = {lane_q, 3'b000};
  assign lane_data = mem_read_data >> shift;
  assign lane_mask = size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff;
  assign load_data = size_q == 2'b10 ? lane_data :
                     size_q == 2'b01 ? {{16{signed_q & lane_data[15]}}, lane_data[15:0]} :
                                       {{24{signed_q & lane_data[7]}}, lane_data[7:0]};
  // until MERGE, mem_write_data doubles as the latched right-aligned store data
  assign merged_data = (mem_read_data & ~(lane_mask << shift)) | ((mem_write_data & lane_mask) << shift);
  always_ff @(posedge system_clock or negedge system_reset_n)
    if (!system_reset_n) begin
      state <= IDLE;
      size_q <= '0;
      lane_q <= '0;
      signed_q <= 1'b0;
      response_valid <= 1'b0;
      response_error <= 1'b0;
      response_read_data <= '0;
      mem_write_enable <= 1'b0;
      mem_address <= '0;
      mem_write_data <= '0;
    end else
      case (state)
        IDLE: if (request_valid) begin
          size_q <= request_size;
          lane_q <= request_address[1:0];
          signed_q <= request_signed;
          mem_address <= {request_address[31:2], 2'b00};
          mem_write_data <= request_write_data;
          if (request_fault) begin
            state <= RESP;
            response_valid <= 1'b1;
            response_error <= 1'b1;
          end else if (!request_write)
            state <= LOAD;
          else if (request_size == 2'b10) begin
            state <= WRITE;
            mem_write_enable <= 1'b1;
          end else
            state <= MERGE;
        end
        LOAD: begin
          response_read_data <= load_data;
          response_valid <= 1'b1;
          state <= RESP;
        end
        MERGE: begin
          mem_write_data <= merged_data;
          mem_write_enable <= 1'b1;
          state <= WRITE;
        end
        WRITE: begin
          mem_write_enable <= 1'b0;
          response_valid <= 1'b1;
          state <= RESP;
        end
        default: begin
          response_valid <= 1'b0;
          response_error <= 1'b0;
          response_read_data <= '0;
          state <= IDLE;
        end
      endcase
endmodule
